// File: rtl/uart_string_tx.sv
// rtl/uart_string_tx.sv - fixed-string 8N1 UART transmitter (message sequencer + serializer)
//
// Sends the MSG_LEN-byte string MSG (byte 0 in the MSBs) once per accepted
// send request, as back-to-back 8N1 frames paced by baud_tick.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   baud_tick in   one-clk pulse per bit period
//   send      in   start request, sampled only while idle
//   tx        out  serial line, idles high (registered)
//   busy      out  high from send acceptance until the last stop bit ends (registered)
//   done      out  one-cycle pulse when the last stop bit ends (registered)

module uart_string_tx #(
   parameter int                   MSG_LEN = 6,
   parameter logic [8*MSG_LEN-1:0] MSG     = 48'h504F4C4F0D0A
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic send,
   output logic tx,
   output logic busy,
   output logic done
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARM   = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   logic [2:0]       state;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [IDX_W-1:0] byte_idx;
   logic [IDX_W-1:0] nxt_idx;
   logic [IDX_W-1:0] sel_idx;
   logic [7:0]       load_byte;
   logic             last_byte;

   assign nxt_idx   = byte_idx + 1'b1;
   assign last_byte = (byte_idx == IDX_W'(MSG_LEN - 1));

   // The shift register is loaded from ARM (always byte 0) or from STOP
   // (the following byte), so the mux index is chosen by state.
   always_comb begin
      sel_idx   = (state == ST_STOP) ? nxt_idx : '0;
      load_byte = 8'h00;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            load_byte = MSG[8*(MSG_LEN-1-i) +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         shreg    <= 8'h00;
         bit_cnt  <= 3'd0;
         byte_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A tick coinciding with acceptance is deliberately not used;
               // ARM waits for the next one so the start bit is a full period.
               if (send) begin
                  state    <= ST_ARM;
                  busy     <= 1'b1;
                  byte_idx <= '0;
               end
            end
            ST_ARM: begin
               if (baud_tick) begin
                  shreg <= load_byte;
                  tx    <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  tx      <= shreg[0];
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_cnt <= 3'd0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  // bit_cnt counts data bits already completed on the line
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (baud_tick) begin
                  if (last_byte) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     byte_idx <= nxt_idx;
                     shreg    <= load_byte;
                     tx       <= 1'b0;
                     state    <= ST_START;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
